plic_lite: RTL and testbench
============================

// Module: plic_lite
// PURPOSE
//  Parametrised platform interrupt controller feeding the machine-mode CSR block's external-interrupt bit (mip[11]).
//  Replaces the single flat peripheral_int_code input with:
//   - NUM_SRC gated sources, each with a per-source priority, enable and level/edge mode
//   - a global priority threshold
//   - a claim/complete handshake over a simple word-addressed register port
//  Sits between peripherals and registers_csr. ext_irq drives mip[11]; claim_id replaces cur_int_code.
// PARAMETERS
//  NUM_SRC    8      number of sources, ids 1..NUM_SRC (id 0 = "none"); legal range 1..31
//  PRIO_W     3      priority width; priority 0 = never interrupts
//  EDGE_MASK  32'h0  bit i=1 -> source i is rising-edge triggered, 0 -> level (bit 0 ignored)
//  XLEN       32     register data width
// PORTS
//  clk        in   1        core clock
//  rst        in   1        asynchronous, active-high reset
//  src_irq    in   NUM_SRC  raw source lines; bit k = source id k+1, already synchronous to clk
//  reg_addr   in   7        word index into the register map
//  reg_we     in   1        write strobe, one cycle
//  reg_re     in   1        read strobe, one cycle; reg_we and reg_re are never asserted together
//  reg_wdata  in   XLEN     write data
//  reg_rdata  out  XLEN     read data, valid the cycle after reg_re
//  ext_irq    out  1        interrupt request to the CSR block (mip[11])
//  claim_id   out  5        current best candidate id, 0 if none
// BEHAVIOUR
//  Reset: all priorities, enables, threshold, pending, inflight and deferred flags = 0;
//         reg_rdata = 0, ext_irq = 0, claim_id = 0. Reset mid-handshake discards all state.
//  Register map (word index):
//   0x01..NUM_SRC  PRIO[id]      RW, low PRIO_W bits; index 0 and other unmapped indices read 0, writes ignored
//   0x40           PENDING       RO, bit id
//   0x41           ENABLE        RW, bit id; bit 0 is hardwired 0
//   0x42           THRESHOLD     RW, low PRIO_W bits
//   0x43           CLAIM         read = claim, write = complete
//  Gateway, per source:
//   - Level mode: pending is set while src high and the source is not inflight.
//   - Edge mode: a 0->1 transition sets pending. If the source is inflight, the edge sets the deferred flag instead.
//     On complete, deferred moves into pending; one deferred edge is held at most, extra edges are merged.
//   - Pending is never set while inflight, except through the deferred path.
//  Arbiter (registered, 1-cycle latency from pending/enable/prio/threshold change to outputs):
//   - candidate = pending & enable & (prio > threshold)
//   - best = highest prio; ties go to the lowest id
//   - claim_id <= best id, or 0 if no candidate; ext_irq <= (candidate exists)
//  Claim, on reg_re at CLAIM:
//   - reg_rdata <= claim_id as registered in that cycle
//   - if nonzero: pending[id] cleared and inflight[id] set in the same edge
//   - a claim when claim_id = 0 returns 0 with no side effect
//  Complete, on reg_we at CLAIM:
//   - if wdata is in 1..NUM_SRC and inflight[wdata]: clear inflight and promote deferred
//   - any other value is ignored silently
//  Simultaneous events:
//   - Source asserts in the same cycle as its claim: clear wins; level mode re-pends after complete.
//   - Complete and new edge on the same source in one cycle: the edge becomes pending.
//  Disabling a pending source: it stays pending but is masked from the arbiter.
//  Priority writes take effect on the next arbitration cycle.
// STRUCTURE
//  - Shared package irq_pkg: register word indices (PRIO_BASE, PENDING_IDX, ENABLE_IDX, THRESH_IDX, CLAIM_IDX)
//    and ID_W = 5.
//  - Sub-module plic_gateway: one per source via generate. Holds edge detect, pending, inflight and deferred.
//    Inputs: claim_hit, complete_hit.
//  - Arbiter and register file in the top level: linear priority scan in an always @(*) block, registered outputs.
// TESTING
//  1. Reset with rst=1 during activity -> all outputs 0, PENDING reads 0, a claim read returns 0.
//  2. PRIO[3]=2, PRIO[5]=2, ENABLE=0x28, THRESH=0; raise src 3 and 5 (level)
//     -> ext_irq=1 one cycle later, claim returns 3, next claim returns 5, ext_irq=0 afterwards.
//  3. PRIO[2]=1, THRESH=1, src 2 high -> ext_irq stays 0; write THRESH=0 -> ext_irq=1 after 1 cycle.
//  4. EDGE_MASK bit 4; pulse src 4, claim (returns 4), pulse src 4 twice while inflight
//     -> PENDING bit4=0; complete 4 -> bit4=1; claim returns 4 once only.
//  5. Complete with wdata=0, 9 or a non-inflight id -> no state change; a level source held high stays blocked.
//  6. Level src 1 held high, claim then complete in back-to-back cycles -> re-pends, ext_irq reasserts two cycles after complete.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the platform interrupt controller:
// register word indices and the width of a source id.
package irq_pkg;

    localparam int ID_W = 5;

    localparam logic [6:0] PRIO_BASE   = 7'h01;
    localparam logic [6:0] PENDING_IDX = 7'h40;
    localparam logic [6:0] ENABLE_IDX  = 7'h41;
    localparam logic [6:0] THRESH_IDX  = 7'h42;
    localparam logic [6:0] CLAIM_IDX   = 7'h43;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: edge/level detection plus the
// pending, inflight and deferred flags of one source.
module plic_gateway #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending
);

    logic src_q;
    logic inflight;
    logic deferred;
    logic rise;
    logic set_now;

    assign rise    = src & ~src_q;
    assign set_now = EDGE ? rise : src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= 1'b0;
            pending  <= 1'b0;
            inflight <= 1'b0;
            deferred <= 1'b0;
        end else begin
            src_q <= src;
            if (claim_hit) begin
                pending  <= 1'b0;
                inflight <= 1'b1;
            end else if (complete_hit && inflight) begin
                // A level source re-pends on the following cycle instead.
                inflight <= 1'b0;
                deferred <= 1'b0;
                pending  <= pending | (EDGE & (deferred | rise));
            end else begin
                pending <= pending | (set_now & ~inflight);
                if (EDGE && rise && inflight) begin
                    deferred <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/plic_lite.sv
// Platform interrupt controller: per-source gateways, register file
// and a registered highest-priority arbiter driving mip[11].
module plic_lite
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter int          PRIO_W    = 3,
    parameter logic [31:0] EDGE_MASK = 32'h0,
    parameter int          XLEN      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic [6:0]         reg_addr,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [XLEN-1:0]    reg_wdata,
    output logic [XLEN-1:0]    reg_rdata,
    output logic               ext_irq,
    output logic [ID_W-1:0]    claim_id
);

    logic [PRIO_W-1:0] prio [1:NUM_SRC];
    logic [NUM_SRC:0]  enable;
    logic [PRIO_W-1:0] threshold;
    logic [NUM_SRC:0]  pending;
    logic [NUM_SRC:0]  claim_hit;
    logic [NUM_SRC:0]  complete_hit;

    logic              claim_sel;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;
    logic              found;
    logic [XLEN-1:0]   rd_val;

    assign claim_sel       = (reg_addr == CLAIM_IDX);
    assign pending[0]      = 1'b0;
    assign claim_hit[0]    = 1'b0;
    assign complete_hit[0] = 1'b0;

    for (genvar k = 1; k <= NUM_SRC; k++) begin : g_src
        assign claim_hit[k] = reg_re && claim_sel &&
                              (claim_id == ID_W'(k));
        assign complete_hit[k] = reg_we && claim_sel &&
                                 (reg_wdata == XLEN'(k));

        plic_gateway #(
            .EDGE(EDGE_MASK[k])
        ) u_gw (
            .clk         (clk),
            .rst         (rst),
            .src         (src_irq[k-1]),
            .claim_hit   (claim_hit[k]),
            .complete_hit(complete_hit[k]),
            .pending     (pending[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                prio[i] <= '0;
            end
            enable    <= '0;
            threshold <= '0;
        end else if (reg_we) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (reg_addr == PRIO_BASE + 7'(i - 1)) begin
                    prio[i] <= reg_wdata[PRIO_W-1:0];
                end
            end
            if (reg_addr == ENABLE_IDX) begin
                enable <= {reg_wdata[NUM_SRC:1], 1'b0};
            end
            if (reg_addr == THRESH_IDX) begin
                threshold <= reg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Strictly-greater compare in ascending id order keeps the lowest id on ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold) &&
                (!found || (prio[i] > best_prio))) begin
                found     = 1'b1;
                best_id   = ID_W'(i);
                best_prio = prio[i];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (reg_addr == PENDING_IDX) begin
            rd_val[NUM_SRC:0] = pending;
        end else if (reg_addr == ENABLE_IDX) begin
            rd_val[NUM_SRC:0] = enable;
        end else if (reg_addr == THRESH_IDX) begin
            rd_val[PRIO_W-1:0] = threshold;
        end else if (claim_sel) begin
            rd_val[ID_W-1:0] = claim_id;
        end else begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (reg_addr == PRIO_BASE + 7'(i - 1)) begin
                    rd_val[PRIO_W-1:0] = prio[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            claim_id  <= '0;
            ext_irq   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            claim_id <= best_id;
            ext_irq  <= found;
            if (reg_re) begin
                reg_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_plic_lite.sv
// Randomised bench for plic_lite against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_plic_lite;
    import irq_pkg::*;

    localparam int          N  = 8;
    localparam logic [31:0] EM = 32'h0000_0090;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  src_irq = '0;
    logic [6:0]    reg_addr = '0;
    logic          reg_we = 1'b0;
    logic          reg_re = 1'b0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          ext_irq;
    logic [4:0]    claim_id;

    always #5 clk = ~clk;

    plic_lite #(
        .NUM_SRC  (N),
        .PRIO_W   (3),
        .EDGE_MASK(EM),
        .XLEN     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_irq  (src_irq),
        .reg_addr (reg_addr),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .ext_irq  (ext_irq),
        .claim_id (claim_id)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int   m_prio [1:N], n_prio [1:N];
    bit   m_en   [1:N], n_en   [1:N];
    bit   m_pend [1:N], n_pend [1:N];
    bit   m_infl [1:N], n_infl [1:N];
    bit   m_def  [1:N], n_def  [1:N];
    bit   m_prev [1:N], n_prev [1:N];
    int   m_thr, n_thr;
    int   m_claim, n_claim;
    bit   m_ext, n_ext;
    bit   m_rvalid, n_rvalid;
    logic [31:0] m_rdata, n_rdata;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 1; i <= N; i++) begin
            m_prio[i] = 0; m_en[i] = 0; m_pend[i] = 0;
            m_infl[i] = 0; m_def[i] = 0; m_prev[i] = 0;
        end
        m_thr = 0; m_claim = 0; m_ext = 0;
        m_rvalid = 1; m_rdata = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [6:0] a);
        logic [31:0] v;
        v = '0;
        if (a >= 7'd1 && a <= 7'(N)) v = 32'(m_prio[int'(a)]);
        else if (a == PENDING_IDX)
            for (int i = 1; i <= N; i++) v[i] = m_pend[i];
        else if (a == ENABLE_IDX)
            for (int i = 1; i <= N; i++) v[i] = m_en[i];
        else if (a == THRESH_IDX) v = 32'(m_thr);
        else if (a == CLAIM_IDX) v = 32'(m_claim);
        return v;
    endfunction

    task automatic model_next();
        int  best, bp, claimed, completed;
        bit  s, rise, edg;
        n_prio = m_prio; n_en = m_en; n_pend = m_pend;
        n_infl = m_infl; n_def = m_def; n_prev = m_prev;
        n_thr = m_thr; n_claim = m_claim; n_ext = m_ext;
        n_rdata = m_rdata; n_rvalid = 0;
        if (rst) begin
            for (int i = 1; i <= N; i++) begin
                n_prio[i] = 0; n_en[i] = 0; n_pend[i] = 0;
                n_infl[i] = 0; n_def[i] = 0; n_prev[i] = 0;
            end
            n_thr = 0; n_claim = 0; n_ext = 0;
            n_rvalid = 1; n_rdata = '0;
            return;
        end
        best = 0; bp = 0;
        for (int i = 1; i <= N; i++)
            if (m_pend[i] && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
                best = i; bp = m_prio[i];
            end
        n_claim = best;
        n_ext = (best != 0);
        n_rvalid = reg_re;
        if (reg_re) n_rdata = model_read(reg_addr);
        claimed = (reg_re && reg_addr == CLAIM_IDX) ? m_claim : 0;
        completed = 0;
        if (reg_we && reg_addr == CLAIM_IDX && reg_wdata >= 1 &&
            reg_wdata <= N && m_infl[int'(reg_wdata)])
            completed = int'(reg_wdata);
        if (reg_we) begin
            if (reg_addr >= 7'd1 && reg_addr <= 7'(N))
                n_prio[int'(reg_addr)] = int'(reg_wdata[2:0]);
            if (reg_addr == ENABLE_IDX)
                for (int i = 1; i <= N; i++) n_en[i] = reg_wdata[i];
            if (reg_addr == THRESH_IDX) n_thr = int'(reg_wdata[2:0]);
        end
        for (int i = 1; i <= N; i++) begin
            s = src_irq[i-1];
            rise = s && !m_prev[i];
            edg = EM[i];
            n_prev[i] = s;
            if (i == claimed) begin
                n_pend[i] = 0; n_infl[i] = 1;
            end else if (i == completed) begin
                n_infl[i] = 0; n_def[i] = 0;
                n_pend[i] = m_pend[i] || (edg && (m_def[i] || rise));
            end else if (edg) begin
                if (rise && m_infl[i]) n_def[i] = 1;
                else if (rise) n_pend[i] = 1;
            end else if (s && !m_infl[i]) begin
                n_pend[i] = 1;
            end
        end
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        m_prio = n_prio; m_en = n_en; m_pend = n_pend;
        m_infl = n_infl; m_def = n_def; m_prev = n_prev;
        m_thr = n_thr; m_claim = n_claim; m_ext = n_ext;
        m_rdata = n_rdata; m_rvalid = n_rvalid;
        #1;
        reg_we = 1'b0;
        reg_re = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_we = 1'b1;
        cycle();
    endtask

    task automatic rd(input logic [6:0] a, output logic [31:0] d);
        reg_addr = a; reg_re = 1'b1;
        cycle();
        d = reg_rdata;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        idle(n);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("claim_id", 32'(claim_id), 32'(m_claim));
            check("ext_irq", 32'(ext_irq), 32'(m_ext));
            if (m_rvalid) check("reg_rdata", reg_rdata, m_rdata);
        end
    end

    initial begin
        logic [31:0] d;
        int r;
        #1;
        do_reset(2);
        chk_en = 1'b1;

        // Reset during activity
        wr(7'd1, 32'd5); wr(ENABLE_IDX, 32'h2);
        src_irq = 8'h01; idle(3);
        rd(CLAIM_IDX, d);
        src_irq = 8'h00;
        do_reset(2);
        check("rst_ext", 32'(ext_irq), 32'd0);
        check("rst_claim_id", 32'(claim_id), 32'd0);
        rd(PENDING_IDX, d); check("rst_pending", d, 32'd0);
        rd(CLAIM_IDX, d);   check("rst_claim_rd", d, 32'd0);

        // Equal priorities, lowest id wins
        wr(7'd3, 32'd2); wr(7'd5, 32'd2);
        wr(ENABLE_IDX, 32'h28); wr(THRESH_IDX, 32'd0);
        src_irq = 8'h14;
        cycle(); check("t2_ext_lat0", 32'(ext_irq), 32'd0);
        cycle(); check("t2_ext_lat1", 32'(ext_irq), 32'd1);
        src_irq = 8'h00;
        rd(CLAIM_IDX, d); check("t2_claim3", d, 32'd3);
        idle(1);
        rd(CLAIM_IDX, d); check("t2_claim5", d, 32'd5);
        idle(2); check("t2_ext_off", 32'(ext_irq), 32'd0);
        wr(CLAIM_IDX, 32'd3); wr(CLAIM_IDX, 32'd5);

        // Threshold masking
        wr(7'd2, 32'd1); wr(THRESH_IDX, 32'd1); wr(ENABLE_IDX, 32'h04);
        src_irq = 8'h02; idle(3);
        check("t3_masked", 32'(ext_irq), 32'd0);
        wr(THRESH_IDX, 32'd0);
        check("t3_lat0", 32'(ext_irq), 32'd0);
        cycle(); check("t3_lat1", 32'(ext_irq), 32'd1);
        src_irq = 8'h00;
        rd(CLAIM_IDX, d); check("t3_claim2", d, 32'd2);
        wr(CLAIM_IDX, 32'd2); idle(2);

        // Edge source with deferred re-trigger
        wr(7'd4, 32'd3); wr(ENABLE_IDX, 32'h10);
        src_irq = 8'h08; cycle(); src_irq = 8'h00; idle(2);
        rd(CLAIM_IDX, d); check("t4_claim4", d, 32'd4);
        src_irq = 8'h08; cycle(); src_irq = 8'h00; cycle();
        src_irq = 8'h08; cycle(); src_irq = 8'h00; cycle();
        rd(PENDING_IDX, d); check("t4_pend_blocked", d & 32'h10, 32'h0);
        wr(CLAIM_IDX, 32'd4);
        rd(PENDING_IDX, d); check("t4_pend_deferred", d & 32'h10, 32'h10);
        idle(1);
        rd(CLAIM_IDX, d); check("t4_reclaim", d, 32'd4);
        idle(2);
        rd(CLAIM_IDX, d); check("t4_once", d, 32'd0);
        wr(CLAIM_IDX, 32'd4);

        // Bogus completes leave the inflight level source blocked
        wr(7'd1, 32'd1); wr(ENABLE_IDX, 32'h02);
        src_irq = 8'h01; idle(2);
        rd(CLAIM_IDX, d); check("t5_claim1", d, 32'd1);
        wr(CLAIM_IDX, 32'd0); wr(CLAIM_IDX, 32'd9); wr(CLAIM_IDX, 32'd2);
        idle(3);
        check("t5_ext", 32'(ext_irq), 32'd0);
        rd(PENDING_IDX, d); check("t5_pend", d, 32'd0);
        wr(CLAIM_IDX, 32'd1);

        // Back-to-back claim/complete on a held level source
        idle(3);
        rd(CLAIM_IDX, d); check("t6_claim1", d, 32'd1);
        wr(CLAIM_IDX, 32'd1);
        check("t6_ext_c0", 32'(ext_irq), 32'd0);
        cycle(); check("t6_ext_c1", 32'(ext_irq), 32'd0);
        cycle(); check("t6_ext_c2", 32'(ext_irq), 32'd1);
        src_irq = 8'h00;

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) src_irq[b] = ~src_irq[b];
            r = int'($urandom_range(99));
            if ($urandom_range(799) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
                continue;
            end
            if (r < 10) begin
                case ($urandom_range(3))
                    0: reg_addr = 7'($urandom_range(1, N));
                    1: reg_addr = ENABLE_IDX;
                    2: reg_addr = THRESH_IDX;
                    default: reg_addr = 7'($urandom_range(127));
                endcase
                reg_wdata = $urandom; reg_we = 1'b1;
            end else if (r < 25) begin
                reg_addr = CLAIM_IDX; reg_re = 1'b1;
            end else if (r < 35) begin
                reg_addr = CLAIM_IDX;
                reg_wdata = 32'($urandom_range(0, N + 2)); reg_we = 1'b1;
            end else if (r < 42) begin
                reg_addr = 7'($urandom_range(127)); reg_re = 1'b1;
            end else if (r < 45) begin
                reg_addr = PENDING_IDX; reg_re = 1'b1;
            end
            cycle();
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
